// File: rtl/gtxe2_chnl_pkg.sv
// Shared constants, types and elaboration checks for the GTXE2 channel model.
package gtxe2_chnl_pkg;

  // K28.5 comma character, byte value before 8b/10b encoding.
  localparam logic [7:0] K28_5 = 8'hBC;

  // What an output slot carries.
  typedef enum logic [1:0] {
    SLOT_FILL,   // lane 0 slot with nothing buffered
    SLOT_FIRST,  // lane 0 of a freshly popped word
    SLOT_NEXT    // lane 1..div-1 taken from the hold register
  } slot_e;

  // The user word must split into exactly 1, 2 or 4 narrow words.
  function automatic bit div_ok(input int unsigned wide, input int unsigned narrow);
    int unsigned d;
    if (narrow == 0 || (wide % narrow) != 0) return 1'b0;
    d = wide / narrow;
    return (d == 1) || (d == 2) || (d == 4);
  endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_dataiface_if.sv
// User-side word handshake of the TX data interface.
interface gtxe2_chnl_tx_dataiface_if #(
  parameter int unsigned interface_data_width = 32,
  parameter int unsigned interface_isk_width  = 4
) ();

  logic [interface_data_width-1:0] indata;
  logic [interface_isk_width-1:0]  inisk;
  logic                            inval;
  logic                            inready;

  modport master (output indata, output inisk, output inval, input inready);
  modport slave  (input indata, input inisk, input inval, output inready);

endinterface

// File: rtl/gtxe2_chnl_tx_fifo2.sv
// Two-entry single-clock FIFO holding whole user words.
module gtxe2_chnl_tx_fifo2 #(
  parameter int unsigned width = 36
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [width-1:0] wdata,
  output logic [width-1:0] head,
  output logic [1:0]       cnt,
  output logic             full,
  output logic             empty
);

  logic [width-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == 2'd2);
  assign empty   = (cnt == 2'd0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage: write the incoming word into the free slot.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; push and pop may coincide at cnt == 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/gtxe2_chnl_tx_dataiface.sv
// TX data width adapter: buffers wide user words and serializes them into
// narrow lanes for the 8b/10b encoder, one lane per usrclk cycle.
// Optional macro GTXE2_CHNL_TX_UNDERFLOW_FILL_EN: underflow slots carry K28.5
// in byte 0 instead of all zeros.
module gtxe2_chnl_tx_dataiface
  import gtxe2_chnl_pkg::*;
#(
  parameter int unsigned internal_data_width  = 16,
  parameter int unsigned interface_data_width = 32,
  parameter int unsigned internal_isk_width   = 2,
  parameter int unsigned interface_isk_width  = 4
) (
  input  logic                           usrclk,
  input  logic                           reset,
  gtxe2_chnl_tx_dataiface_if.slave       in_if,
  output logic [internal_data_width-1:0] outdata,
  output logic [internal_isk_width-1:0]  outisk,
  output logic                           outval,
  output logic                           outphase,
  output logic                           underflow
);

  localparam int unsigned DIV    = interface_data_width / internal_data_width;
  localparam int unsigned WORD_W = interface_isk_width + interface_data_width;

  if (!div_ok(interface_data_width, internal_data_width)) begin : g_div_check
    $error("gtxe2_chnl_tx_dataiface: interface/internal width ratio must be 1, 2 or 4");
  end

  logic [WORD_W-1:0]              fifo_head;
  logic [1:0]                     fifo_cnt;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           push;
  logic                           pop;
  logic [WORD_W-1:0]              hold;
  logic [1:0]                     lane;
  logic [1:0]                     lane_next;
  slot_e                          slot;
  logic [internal_data_width-1:0] slice_data;
  logic [internal_isk_width-1:0]  slice_isk;

  assign in_if.inready = ~reset & (fifo_cnt != 2'd2);
  assign push          = in_if.inval & ~fifo_full & ~reset;
  assign pop           = (slot == SLOT_FIRST) & ~reset;

  gtxe2_chnl_tx_fifo2 #(
    .width (WORD_W)
  ) u_fifo (
    .clk   (usrclk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata ({in_if.inisk, in_if.indata}),
    .head  (fifo_head),
    .cnt   (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Slot decode and lane selection. Lane 0 comes straight from the FIFO head
  // so a word can start the cycle after it is accepted; later lanes come from
  // the hold register because the head has already been popped.
  always_comb begin
    slice_data = '0;
    slice_isk  = '0;
    lane_next  = 2'd0;
    if (lane != 2'd0)   slot = SLOT_NEXT;
    else if (fifo_empty) slot = SLOT_FILL;
    else                slot = SLOT_FIRST;
    unique case (slot)
      SLOT_FIRST: begin
        slice_data = fifo_head[internal_data_width-1:0];
        slice_isk  = fifo_head[interface_data_width +: internal_isk_width];
        lane_next  = (DIV == 1) ? 2'd0 : 2'd1;
      end
      SLOT_NEXT: begin
        for (int unsigned k = 0; k < DIV; k++) begin
          if (32'(lane) == k) begin
            slice_data = hold[k*internal_data_width +: internal_data_width];
            slice_isk  = hold[interface_data_width + k*internal_isk_width +: internal_isk_width];
          end
        end
        lane_next = (32'(lane) == DIV - 1) ? 2'd0 : lane + 2'd1;
      end
      SLOT_FILL: begin
`ifdef GTXE2_CHNL_TX_UNDERFLOW_FILL_EN
        slice_data[7:0] = K28_5;
        slice_isk[0]    = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  // Lane counter, hold register and registered outputs; reset drops any
  // partially sent word.
  always_ff @(posedge usrclk) begin
    if (reset) begin
      hold      <= '0;
      lane      <= 2'd0;
      outdata   <= '0;
      outisk    <= '0;
      outval    <= 1'b0;
      outphase  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (slot == SLOT_FIRST) hold <= fifo_head;
      lane      <= lane_next;
      outdata   <= slice_data;
      outisk    <= slice_isk;
      outval    <= (slot != SLOT_FILL);
      outphase  <= (slot == SLOT_FIRST);
      underflow <= (slot == SLOT_FILL);
    end
  end

endmodule

// File: tb/tb_gtxe2_chnl_tx_dataiface.sv
// Self-checking bench for gtxe2_chnl_tx_dataiface in div = 2, 4 and 1 builds.
module tb_gtxe2_chnl_tx_dataiface;

`ifdef GTXE2_CHNL_TX_UNDERFLOW_FILL_EN
  localparam logic [15:0] FILL_D2 = 16'h00BC;
  localparam logic [1:0]  FILL_I2 = 2'b01;
`else
  localparam logic [15:0] FILL_D2 = 16'h0000;
  localparam logic [1:0]  FILL_I2 = 2'b00;
`endif

  logic usrclk;
  logic reset;
  int   checks;
  int   failures;

  initial usrclk = 1'b0;
  always #5 usrclk = ~usrclk;

  gtxe2_chnl_tx_dataiface_if #(.interface_data_width(32), .interface_isk_width(4)) if2 ();
  gtxe2_chnl_tx_dataiface_if #(.interface_data_width(64), .interface_isk_width(8)) if4 ();
  gtxe2_chnl_tx_dataiface_if #(.interface_data_width(32), .interface_isk_width(4)) if1 ();

  logic [15:0] o2_data; logic [1:0] o2_isk; logic o2_val, o2_ph, o2_uf;
  logic [15:0] o4_data; logic [1:0] o4_isk; logic o4_val, o4_ph, o4_uf;
  logic [31:0] o1_data; logic [3:0] o1_isk; logic o1_val, o1_ph, o1_uf;

  gtxe2_chnl_tx_dataiface #(
    .internal_data_width(16), .interface_data_width(32),
    .internal_isk_width(2), .interface_isk_width(4)
  ) u2 (
    .usrclk(usrclk), .reset(reset), .in_if(if2),
    .outdata(o2_data), .outisk(o2_isk), .outval(o2_val), .outphase(o2_ph), .underflow(o2_uf)
  );

  gtxe2_chnl_tx_dataiface #(
    .internal_data_width(16), .interface_data_width(64),
    .internal_isk_width(2), .interface_isk_width(8)
  ) u4 (
    .usrclk(usrclk), .reset(reset), .in_if(if4),
    .outdata(o4_data), .outisk(o4_isk), .outval(o4_val), .outphase(o4_ph), .underflow(o4_uf)
  );

  gtxe2_chnl_tx_dataiface #(
    .internal_data_width(32), .interface_data_width(32),
    .internal_isk_width(4), .interface_isk_width(4)
  ) u1 (
    .usrclk(usrclk), .reset(reset), .in_if(if1),
    .outdata(o1_data), .outisk(o1_isk), .outval(o1_val), .outphase(o1_ph), .underflow(o1_uf)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  isk;
    logic [15:0] lo;
    logic [15:0] hi;
    logic [1:0]  isk_lo;
    logic [1:0]  isk_hi;
  } vec_t;

  // Reference model for the div = 2 build: words waiting in the buffer,
  // the word being sent and how many of its lanes have gone out.
  logic [35:0]  mq[$];
  logic [35:0]  mcur;
  int unsigned  mlane;
  int           ov_count;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge usrclk);
    #1;
  endtask

  // Output stream rule: finish the current word, else start the oldest
  // buffered word, else report underflow with the fill word.
  task automatic model_check();
    logic [15:0] ed;
    logic [1:0]  ei;
    logic        ev, ep, eu;
    if (mlane != 0) begin
      ed = 16'(mcur[31:0] >> (16 * mlane));
      ei = 2'(mcur[35:32] >> (2 * mlane));
      ev = 1'b1; ep = 1'b0; eu = 1'b0;
      mlane = (mlane + 1) % 2;
    end else if (mq.size() > 0) begin
      mcur = mq.pop_front();
      ed = mcur[15:0];
      ei = mcur[33:32];
      ev = 1'b1; ep = 1'b1; eu = 1'b0;
      mlane = 1;
    end else begin
      ed = FILL_D2; ei = FILL_I2;
      ev = 1'b0; ep = 1'b0; eu = 1'b1;
    end
    check("m_outval", 64'(o2_val), 64'(ev));
    check("m_outphase", 64'(o2_ph), 64'(ep));
    check("m_underflow", 64'(o2_uf), 64'(eu));
    check("m_outdata", 64'(o2_data), 64'(ed));
    check("m_outisk", 64'(o2_isk), 64'(ei));
  endtask

  task automatic step2(input logic v, input logic [31:0] d, input logic [3:0] k,
                       input logic r, output logic acc);
    if2.inval  = v;
    if2.indata = d;
    if2.inisk  = k;
    reset      = r;
    #1;
    check("m_inready", 64'(if2.inready), 64'(!r && mq.size() < 2));
    acc = v & if2.inready;
    tick();
    if (o2_val) ov_count++;
    if (r) begin
      check("m_rst_outdata", 64'(o2_data), 64'd0);
      check("m_rst_outval", 64'(o2_val), 64'd0);
      check("m_rst_underflow", 64'(o2_uf), 64'd0);
      mq.delete();
      mlane = 0;
    end else begin
      model_check();
      if (acc) mq.push_back({k, d});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[4];
    logic        acc;
    logic [31:0] bpw[6];
    int          acc_edge[6];
    int          idx;
    logic [15:0] e4d[4];
    logic [1:0]  e4i[4];
    logic [31:0] w1;

    checks = 0; failures = 0; ov_count = 0; mlane = 0; mcur = '0;
    reset = 1'b1;
    if2.inval = 1'b0; if2.indata = '0; if2.inisk = '0;
    if4.inval = 1'b0; if4.indata = '0; if4.inisk = '0;
    if1.inval = 1'b0; if1.indata = '0; if1.inisk = '0;

    vecs[0] = '{32'hA1B2C3D4, 4'b0001, 16'hC3D4, 16'hA1B2, 2'b01, 2'b00};
    vecs[1] = '{32'hFFFF0000, 4'b1100, 16'h0000, 16'hFFFF, 2'b00, 2'b11};
    vecs[2] = '{32'h12345678, 4'b0110, 16'h5678, 16'h1234, 2'b10, 2'b01};
    vecs[3] = '{32'hBC5A3CBC, 4'b1001, 16'h3CBC, 16'hBC5A, 2'b01, 2'b10};

    // Reset state.
    tick(); tick();
    check("rst_outdata", 64'(o2_data), 64'd0);
    check("rst_outisk", 64'(o2_isk), 64'd0);
    check("rst_outval", 64'(o2_val), 64'd0);
    check("rst_outphase", 64'(o2_ph), 64'd0);
    check("rst_underflow", 64'(o2_uf), 64'd0);
    check("rst_inready", 64'(if2.inready), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_inready", 64'(if2.inready), 64'd1);

    // Idle input: fill word every cycle.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fill_underflow", 64'(o2_uf), 64'd1);
      check("fill_outval", 64'(o2_val), 64'd0);
      check("fill_outphase", 64'(o2_ph), 64'd0);
      check("fill_outdata", 64'(o2_data), 64'(FILL_D2));
      check("fill_outisk", 64'(o2_isk), 64'(FILL_I2));
    end

    // Single isolated words, div = 2.
    for (int i = 0; i < 4; i++) begin
      if2.inval = 1'b1; if2.indata = vecs[i].data; if2.inisk = vecs[i].isk;
      tick();
      if2.inval = 1'b0;
      check("tbl_accept_slot_uf", 64'(o2_uf), 64'd1);
      tick();
      check("tbl_lo_data", 64'(o2_data), 64'(vecs[i].lo));
      check("tbl_lo_isk", 64'(o2_isk), 64'(vecs[i].isk_lo));
      check("tbl_lo_phase", 64'(o2_ph), 64'd1);
      check("tbl_lo_val", 64'(o2_val), 64'd1);
      tick();
      check("tbl_hi_data", 64'(o2_data), 64'(vecs[i].hi));
      check("tbl_hi_isk", 64'(o2_isk), 64'(vecs[i].isk_hi));
      check("tbl_hi_phase", 64'(o2_ph), 64'd0);
      check("tbl_hi_val", 64'(o2_val), 64'd1);
      tick();
      check("tbl_after_uf", 64'(o2_uf), 64'd1);
      check("tbl_after_val", 64'(o2_val), 64'd0);
    end

    // Reset right after lane 0 of a word.
    if2.inval = 1'b1; if2.indata = 32'h11112222; if2.inisk = 4'b0000;
    tick();
    if2.inval = 1'b0;
    tick();
    check("rmw_lane0", 64'(o2_data), 64'h2222);
    reset = 1'b1;
    #1;
    check("rmw_inready_in_rst", 64'(if2.inready), 64'd0);
    tick();
    check("rmw_outdata", 64'(o2_data), 64'd0);
    check("rmw_outisk", 64'(o2_isk), 64'd0);
    check("rmw_outval", 64'(o2_val), 64'd0);
    check("rmw_outphase", 64'(o2_ph), 64'd0);
    check("rmw_underflow", 64'(o2_uf), 64'd0);
    check("rmw_inready", 64'(if2.inready), 64'd0);
    reset = 1'b0;
    tick();
    check("rmw_no_lane1_val", 64'(o2_val), 64'd0);
    check("rmw_no_lane1_uf", 64'(o2_uf), 64'd1);
    if2.inval = 1'b1; if2.indata = 32'hCAFEF00D; if2.inisk = 4'b0011;
    tick();
    if2.inval = 1'b0;
    tick();
    check("rmw_next_lo", 64'(o2_data), 64'hF00D);
    check("rmw_next_lo_isk", 64'(o2_isk), 64'h3);
    check("rmw_next_lo_phase", 64'(o2_ph), 64'd1);
    tick();
    check("rmw_next_hi", 64'(o2_data), 64'hCAFE);
    check("rmw_next_hi_phase", 64'(o2_ph), 64'd0);
    tick();

    // div = 4: one 64-bit word.
    e4d[0] = 16'hCDEF; e4d[1] = 16'h89AB; e4d[2] = 16'h4567; e4d[3] = 16'h0123;
    e4i[0] = 2'b10;    e4i[1] = 2'b00;    e4i[2] = 2'b00;    e4i[3] = 2'b01;
    check("d4_inready", 64'(if4.inready), 64'd1);
    if4.inval = 1'b1; if4.indata = 64'h0123456789ABCDEF; if4.inisk = 8'b01000010;
    tick();
    if4.inval = 1'b0;
    check("d4_accept_slot_val", 64'(o4_val), 64'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("d4_data", 64'(o4_data), 64'(e4d[k]));
      check("d4_isk", 64'(o4_isk), 64'(e4i[k]));
      check("d4_phase", 64'(o4_ph), 64'(k == 0));
      check("d4_val", 64'(o4_val), 64'd1);
    end
    tick();
    check("d4_after_val", 64'(o4_val), 64'd0);
    check("d4_after_uf", 64'(o4_uf), 64'd1);

    // div = 1: continuous valid, word out one cycle after acceptance.
    for (int i = 0; i <= 6; i++) begin
      if (i < 6) begin
        w1 = 32'h10203040 + 32'h01010101 * 32'(i);
        if1.inval = 1'b1; if1.indata = w1; if1.inisk = 4'(i);
        #1;
        check("d1_inready", 64'(if1.inready), 64'd1);
      end else begin
        if1.inval = 1'b0;
      end
      tick();
      if (i == 0) begin
        check("d1_first_val", 64'(o1_val), 64'd0);
      end else begin
        check("d1_data", 64'(o1_data), 64'(32'h10203040 + 32'h01010101 * 32'(i - 1)));
        check("d1_isk", 64'(o1_isk), 64'(i - 1));
        check("d1_val", 64'(o1_val), 64'd1);
        check("d1_phase", 64'(o1_ph), 64'd1);
      end
    end
    tick();
    check("d1_idle_uf", 64'(o1_uf), 64'd1);

    // Back-to-back with backpressure, div = 2, against the model.
    step2(1'b0, 32'h0, 4'h0, 1'b1, acc);
    for (int i = 0; i < 6; i++) bpw[i] = 32'hB0B00000 + 32'(i) * 32'h00011111;
    ov_count = 0;
    idx = 0;
    for (int c = 0; c < 40 && idx < 6; c++) begin
      step2(1'b1, bpw[idx], 4'(idx), 1'b0, acc);
      if (acc) begin
        acc_edge[idx] = c;
        idx++;
      end
    end
    check("bp_all_accepted", 64'(idx), 64'd6);
    for (int c = 0; c < 10; c++) step2(1'b0, 32'h0, 4'h0, 1'b0, acc);
    check("bp_outval_cycles", 64'(ov_count), 64'd12);
    for (int i = 3; i < 6; i++)
      check("bp_accept_spacing", 64'(acc_edge[i] - acc_edge[i-1]), 64'd2);

    // Randomized traffic with occasional resets, against the model.
    for (int n = 0; n < 400; n++) begin
      step2($urandom_range(0, 99) < 65, $urandom, 4'($urandom_range(0, 15)),
            $urandom_range(0, 49) == 0, acc);
    end
    for (int c = 0; c < 6; c++) step2(1'b0, 32'h0, 4'h0, 1'b0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gtxe2_chnl_tx_dataiface.md
# gtxe2_chnl_tx_dataiface

Transmit-side data width adapter for the GTXE2 channel model. It accepts wide user words (data plus K-flags) with a valid/ready handshake and emits one narrow internal word per cycle toward the TX 8b/10b encoder. Both sides run on `usrclk`, so the block is a two-entry buffer followed by a lane serializer with defined underflow behaviour.

## Interface
- `internal_data_width`, default 16: width of the narrow word sent to the encoder.
- `interface_data_width`, default 32: width of the user word. It must be an integer multiple of `internal_data_width`, with ratio `div` = 1, 2 or 4.
- `internal_isk_width`, default 2: K-flag bits per narrow word. Each flag covers one byte.
- `interface_isk_width`, default 4: K-flag bits per user word.
- `usrclk`  in  1  the single clock for all logic.
- `reset`  in  1  synchronous, active-high reset.
- `indata`  in  `interface_data_width`  user data. Lane 0 is the LSBs.
- `inisk`  in  `interface_isk_width`  user K-flags, aligned to the `indata` lanes.
- `inval`  in  1  the user word is valid.
- `inready`  out  1  the block can accept a word. A word transfers when `inval & inready` at a rising edge.
- `outdata`  out  `internal_data_width`  narrow data, registered.
- `outisk`  out  `internal_isk_width`  narrow K-flags, registered.
- `outval`  out  1  `outdata`/`outisk` carry a real lane.
- `outphase`  out  1  `outdata` carries lane 0 of a word.
- `underflow`  out  1  one-cycle pulse for each lane-0 slot found with an empty buffer.

## Operation
- **Buffer.** Two-entry FIFO of `{isk, data}` user words, with occupancy `cnt` in the range 0..2.
  - `inready = ~reset & (cnt != 2)`.
  - A push and a pop in the same cycle are legal when `cnt` is 1.
  - A push is never accepted when `cnt` is 2.
- **Serializer.** Lane counter `lane` counts 0..div-1. A hold register keeps the popped word for lanes 1..div-1.
- **Slot with `lane == 0` and FIFO non-empty:**
  - pop the head into the hold register;
  - output the lane-0 slice;
  - `outval = 1`, `outphase = 1`;
  - `lane` becomes 1, or stays 0 when div = 1.
- **Slot with `lane == k`, k > 0:**
  - output slice k of the hold register;
  - `outval = 1`, `outphase = 0`;
  - `lane` becomes (k+1) mod div.
- **Slot with `lane == 0` and FIFO empty (underflow):**
  - output the fill word (see Configuration);
  - `outval = 0`, `outphase = 0`, `underflow = 1`;
  - `lane` stays 0.
  - Words are never split across an underflow gap.
- **Slice k** is `data[(k+1)*internal_data_width-1 -: internal_data_width]`, with the same indexing for isk.
- **Reset** takes priority in any cycle, including mid-word:
  - empties the FIFO, clears the hold register, sets `lane = 0`;
  - `outdata = 0`, `outisk = 0`, `outval = 0`, `outphase = 0`, `underflow = 0`;
  - `inready = 0` during the reset cycle and 1 from the first cycle after reset.
  - Lanes of a partially sent word are discarded.

## Timing
- Latency: a word accepted at edge t, into an empty FIFO with `lane == 0`, shows lane 0 on `outdata` after edge t+1. Lane k shows after edge t+1+k.
- Sustained throughput is one user word every `div` cycles.
- For div = 1, the FIFO is popped every cycle. Throughput is one word per cycle with `inready` held at 1 when the user drives `inval` continuously.
- For div > 1, `inready` drops once the FIFO holds two words and rises in the cycle after the next pop.
- `underflow` is registered and aligned with the fill word it reports.

## Configuration
- Macro: `GTXE2_CHNL_TX_UNDERFLOW_FILL_EN`.
- Defined: an underflow slot outputs `outdata` = `{(internal_data_width/8-1){8'h00}, 8'hBC}` and `outisk` = `{..0, 1'b1}`, i.e. K28.5 in byte 0 with the other bytes zero.
- Undefined: an underflow slot outputs `outdata = 0` and `outisk = 0`.
- `outval`, `outphase` and `underflow` behave the same either way.

## Structure
- The shared package `gtxe2_chnl_pkg` holds:
  - the K28.5 constant `8'hBC`;
  - the allowed-`div` check used by an elaboration-time `$error` when the ratio is not 1, 2 or 4.
- One sub-module, `gtxe2_chnl_tx_fifo2`: the two-entry single-clock buffer with `push`, `pop`, `cnt`, `head`, `full` and `empty`.
- The serializer, lane counter and output registers stay in the top module.

## Test plan
All scenarios use div = 2 (32 -> 16) unless stated.
- **Single word, div = 2.** `inval` for one cycle with `indata = 32'hA1B2C3D4` and `inisk = 4'b0001`. Required: `outdata` shows `16'hC3D4` with isk `2'b01`, `outphase = 1`, then `16'hA1B2` with isk `2'b00`, `outphase = 0`, both with `outval = 1`. After that, underflow slots follow.
- **Back-to-back with backpressure, div = 2.** `inval` held high with words W0..W5. Required: `inready` pattern settles to one accept per 2 cycles, `outval` stays 1 throughout, lanes come out in order and no word is lost or duplicated.
- **Underflow fill.** Idle input after reset. Required: `underflow = 1` every cycle and `outval = 0`. `outdata` is `16'h00BC` with isk `2'b01` when the macro is defined, and 0 with isk 0 otherwise.
- **Reset mid-word.** Assert `reset` for one cycle right after lane 0 of `32'h11112222`. Required: the next cycle shows all outputs at 0 and `inready = 0`. `16'h1111` is never emitted, and after reset the first accepted word starts at lane 0.
- **div = 4.** Configure 64 -> 16 and send `64'h0123456789ABCDEF`. Required: `CDEF`, `89AB`, `4567`, `0123` in order, with `outphase` high only on `CDEF`.
- **div = 1.** Configure 32 -> 32 with continuous `inval`. Required: `inready` stays 1, each word appears one cycle after acceptance, and `outphase = outval`.
